// File: rtl/count_ctrl.sv
// rtl/count_ctrl.sv - start/stop/hold counter with one-shot and auto-reload modes
module count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             ck,
  input  logic             res,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [1:0]       st
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] lim_r;
  logic             go;

  // A start only counts when stop is low; stop wins every tie.
  assign go = start & ~stop;
  assign st = state;

  // Single state machine: state, count, captured limit and registered flags.
  always_ff @(posedge ck) begin
    if (res) begin
      state <= IDLE;
      q     <= '0;
      lim_r <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          q <= '0;
          if (go) begin
            lim_r <= limit;
            if (limit == '0) begin
              // Zero terminal count finishes immediately.
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          busy <= 1'b1;
          if (stop) begin
            // Stop freezes the count even on the terminal cycle.
            state <= HOLD;
          end else if (q != lim_r) begin
            q <= q + WIDTH'(1);
          end else begin
            done <= 1'b1;
            if (mode) begin
              q <= '0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (stop) begin
            state <= IDLE;
            q     <= '0;
            busy  <= 1'b0;
          end else if (start) begin
            // Resume from the frozen count with the original limit.
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            busy <= 1'b1;
          end
        end
        DONE: begin
          if (go) begin
            state <= RUN;
            q     <= '0;
            lim_r <= limit;
            busy  <= 1'b1;
          end else if (stop) begin
            state <= IDLE;
            q     <= '0;
            busy  <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          q     <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
